// File: rtl/drive_seq_pkg.sv
// drive_seq_pkg: shared state encoding for the drive sequencer
package drive_seq_pkg;
  localparam int K_STATE_W = 3;
  typedef enum logic [K_STATE_W-1:0] {
    IDLE     = 3'd0,
    DRIVE    = 3'd1,
    STOPPING = 3'd2,
    DWELL    = 3'd3,
    FAILSAFE = 3'd4
  } drive_state_t;
endpackage

// File: rtl/drive_sequencer_slew_limiter.sv
// slew_limiter: per-motor power ramp toward a target with an immediate zeroing override
module slew_limiter #(
  parameter int K_RES = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_tick,
  input  logic [K_RES-1:0] i_target,
  input  logic [K_RES-1:0] i_step,
  input  logic             i_force_zero,
  output logic [K_RES-1:0] o_value
);
  logic [K_RES-1:0] value_q, value_d;
  logic [K_RES:0]   up_w, dn_w;
  // Move by at most one step per tick; the extra bit lets a step past either end clamp onto the target
  always_comb begin
    up_w    = {1'b0, value_q} + {1'b0, i_step};
    dn_w    = {1'b0, value_q} - {1'b0, i_step};
    value_d = i_force_zero ? '0
            : !i_tick ? value_q
            : (i_step == '0) ? i_target
            : (value_q < i_target) ? ((up_w > {1'b0, i_target}) ? i_target : up_w[K_RES-1:0])
            : ((dn_w[K_RES] || dn_w[K_RES-1:0] < i_target) ? i_target : dn_w[K_RES-1:0]);
  end
  // Power register
  always_ff @(posedge i_clk)
    value_q <= i_rst ? '0 : value_d;
  assign o_value = value_q;
endmodule

// File: rtl/drive_sequencer.sv
// drive_sequencer: command latch, watchdog and direction-change FSM feeding per-motor slew limiters
module drive_sequencer
  import drive_seq_pkg::*;
#(
  parameter int K_NMOT = 2,
  parameter int K_RES  = 8,
  parameter int K_TW   = 16
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_tick,
  input  logic                    i_cmd_valid,
  input  logic [K_RES-1:0]        i_power,
  input  logic                    i_reverse,
  input  logic                    i_brake,
  input  logic [K_RES-1:0]        i_ramp_step,
  input  logic [K_TW-1:0]         i_dwell_thr,
  input  logic [K_TW-1:0]         i_timeout_thr,
  input  logic [K_NMOT*K_RES-1:0] i_trim,
  output logic [K_NMOT*K_RES-1:0] o_power,
  output logic                    o_reverse,
  output logic                    o_brake,
  output logic                    o_failsafe,
  output logic [K_STATE_W-1:0]    o_state
);
  drive_state_t            state_q, state_d;
  logic [K_RES-1:0]        req_power_q, req_power_d;
  logic                    req_reverse_q, req_reverse_d, req_brake_q, req_brake_d;
  logic [K_TW-1:0]         wd_q, wd_d, dwell_q, dwell_d;
  logic                    rev_q, rev_d, brake_q, brake_d;
  logic [K_NMOT*K_RES-1:0] tgt_q, tgt_d;
  logic                    failsafe, timeout, all_zero;
  assign failsafe = state_q == FAILSAFE;
  assign timeout  = i_timeout_thr != '0 && wd_q >= i_timeout_thr;
  assign all_zero = o_power == '0;
  // Command latch, saturating watchdog (a command clear beats a same-cycle tick) and brake output
  always_comb begin
    req_power_d   = i_cmd_valid ? i_power : req_power_q;
    req_reverse_d = i_cmd_valid ? i_reverse : req_reverse_q;
    req_brake_d   = i_cmd_valid ? i_brake : req_brake_q;
    wd_d          = i_cmd_valid ? '0 : (i_tick && wd_q != '1) ? wd_q + 1'b1 : wd_q;
    brake_d       = req_brake_q | failsafe;
  end
  // Sequencing FSM; a timeout overrides every other transition outside IDLE and FAILSAFE
  always_comb begin
    state_d = state_q;
    rev_d   = rev_q;
    dwell_d = dwell_q;
    case (state_q)
      IDLE:     if (i_cmd_valid) state_d = DRIVE;
      FAILSAFE: if (i_cmd_valid && i_power == '0 && !i_brake) state_d = DRIVE;
      default:
        if (timeout) state_d = FAILSAFE;
        else if (state_q == DRIVE) begin
          if (req_reverse_q != rev_q) state_d = STOPPING;
        end
        else if (req_reverse_q == rev_q) state_d = DRIVE;
        else if (state_q == STOPPING) begin
          if (all_zero) begin
            state_d = DWELL;
            dwell_d = '0;
          end
        end
        else if (dwell_q == i_dwell_thr) begin
          state_d = DRIVE;
          rev_d   = !rev_q;
        end
        else if (i_tick) dwell_d = dwell_q + 1'b1;
    endcase
  end
  // Per-motor target follows the next state so a stale target can never drive power up while stopping
  always_comb begin
    tgt_d = '0;
    for (int m = 0; m < K_NMOT; m++)
      tgt_d[m*K_RES +: K_RES] = (state_d == DRIVE && !req_brake_q)
        ? ((req_power_q < i_trim[m*K_RES +: K_RES]) ? req_power_q : i_trim[m*K_RES +: K_RES]) : '0;
  end
  // State registers
  always_ff @(posedge i_clk)
    if (i_rst) begin
      state_q       <= IDLE;
      req_power_q   <= '0;
      req_reverse_q <= 1'b0;
      req_brake_q   <= 1'b0;
      wd_q          <= '0;
      dwell_q       <= '0;
      rev_q         <= 1'b0;
      brake_q       <= 1'b1;
      tgt_q         <= '0;
    end else begin
      state_q       <= state_d;
      req_power_q   <= req_power_d;
      req_reverse_q <= req_reverse_d;
      req_brake_q   <= req_brake_d;
      wd_q          <= wd_d;
      dwell_q       <= dwell_d;
      rev_q         <= rev_d;
      brake_q       <= brake_d;
      tgt_q         <= tgt_d;
    end
  for (genvar m = 0; m < K_NMOT; m++) begin : g_mot
    slew_limiter #(.K_RES(K_RES)) u_slew (
      .i_clk        (i_clk),
      .i_rst        (i_rst),
      .i_tick       (i_tick),
      .i_target     (tgt_q[m*K_RES +: K_RES]),
      .i_step       (i_ramp_step),
      .i_force_zero (req_brake_q | failsafe),
      .o_value      (o_power[m*K_RES +: K_RES])
    );
  end
  assign o_reverse  = rev_q;
  assign o_brake    = brake_q;
  assign o_failsafe = failsafe;
  assign o_state    = state_q;
endmodule
